// File: rtl/opl2_host_writer.sv
`default_nettype none
// opl2_host_writer: turns one register write into address-port and data-port strobes on the OPL2 host bus.
// Rev 1.0 -- initial release.
module opl2_host_writer #(
  parameter int STROBE_LEN          = 2,
  parameter int ADDR_WAIT           = 4,
  parameter int DATA_WAIT           = 24,
  parameter int CNT_WIDTH           = 16,
  parameter int SKIP_REDUNDANT_ADDR = 1,
  parameter int REG_FILE_DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [REG_FILE_DATA_WIDTH-1:0] cmd_reg,
  input  logic [REG_FILE_DATA_WIDTH-1:0] cmd_data,
  output logic                           cs_n,
  output logic                           wr_n,
  output logic                           rd_n,
  output logic                           address,
  output logic [REG_FILE_DATA_WIDTH-1:0] dout,
  output logic                           busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    A_WAIT   = 3'd3,
    D_SETUP  = 3'd4,
    D_STROBE = 3'd5,
    D_WAIT   = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] AWAIT_LOAD  = CNT_WIDTH'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] DWAIT_LOAD  = CNT_WIDTH'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);

  state_t                         state, state_nxt;
  logic [CNT_WIDTH-1:0]           cnt, cnt_nxt;
  logic [REG_FILE_DATA_WIDTH-1:0] reg_q, data_q, last_reg, dout_nxt;
  logic                           last_valid, addr_nxt, strobe_nxt, accept, skip, cnt_done;

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_done  = (cnt == '0);
  assign skip      = (SKIP_REDUNDANT_ADDR != 0) && last_valid && (cmd_reg == last_reg);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_done ? '0 : cnt - CNT_WIDTH'(1);
    addr_nxt  = address;
    dout_nxt  = dout;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = '0;
          if (skip) begin
            state_nxt = D_SETUP;
            addr_nxt  = 1'b1;
            dout_nxt  = cmd_data;
          end else begin
            state_nxt = A_SETUP;
            addr_nxt  = 1'b0;
            dout_nxt  = cmd_reg;
          end
        end
      end
      A_SETUP: begin
        state_nxt = A_STROBE;
        cnt_nxt   = STROBE_LOAD;
      end
      A_STROBE: begin
        if (cnt_done) begin
          if (ADDR_WAIT == 0) begin
            state_nxt = D_SETUP;
            cnt_nxt   = '0;
            addr_nxt  = 1'b1;
            dout_nxt  = data_q;
          end else begin
            state_nxt = A_WAIT;
            cnt_nxt   = AWAIT_LOAD;
          end
        end
      end
      A_WAIT: begin
        if (cnt_done) begin
          state_nxt = D_SETUP;
          cnt_nxt   = '0;
          addr_nxt  = 1'b1;
          dout_nxt  = data_q;
        end
      end
      D_SETUP: begin
        state_nxt = D_STROBE;
        cnt_nxt   = STROBE_LOAD;
      end
      D_STROBE: begin
        if (cnt_done) begin
          if (DATA_WAIT == 0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = D_WAIT;
            cnt_nxt   = DWAIT_LOAD;
          end
        end
      end
      D_WAIT: begin
        if (cnt_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Strobe flops follow the upcoming state so the bus pins stay purely registered.
    strobe_nxt = (state_nxt == A_STROBE) || (state_nxt == D_STROBE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      rd_n       <= 1'b1;
      address    <= 1'b0;
      dout       <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      last_reg   <= '0;
      last_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cs_n    <= !strobe_nxt;
      wr_n    <= !strobe_nxt;
      rd_n    <= 1'b1;
      address <= addr_nxt;
      dout    <= dout_nxt;
      if (accept) begin
        reg_q  <= cmd_reg;
        data_q <= cmd_data;
      end
      if ((state == A_STROBE) && cnt_done) begin
        last_reg   <= reg_q;
        last_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opl2_host_writer.sv
`default_nettype none
// tb_opl2_host_writer: bench with a cycle-position model of the write sequence for two parameterisations.
// Rev 1.0 -- initial release.
module tb_opl2_host_writer;

  localparam int SL0 = 2, AW0 = 4, DW0 = 24, SK0 = 1;
  localparam int SL1 = 1, AW1 = 0, DW1 = 0,  SK1 = 0;
  localparam int SL [2] = '{SL0, SL1};
  localparam int AW [2] = '{AW0, AW1};
  localparam int DW [2] = '{DW0, DW1};
  localparam int SK [2] = '{SK0, SK1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cv   [2];
  logic [7:0] creg [2];
  logic [7:0] cdat [2];
  logic       rdy  [2];
  logic       csn  [2];
  logic       wrn  [2];
  logic       rdn  [2];
  logic       adr  [2];
  logic       bsy  [2];
  logic [7:0] dout [2];

  opl2_host_writer #(.STROBE_LEN(SL0), .ADDR_WAIT(AW0), .DATA_WAIT(DW0),
                     .CNT_WIDTH(16), .SKIP_REDUNDANT_ADDR(SK0), .REG_FILE_DATA_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_reg(creg[0]), .cmd_data(cdat[0]), .cs_n(csn[0]), .wr_n(wrn[0]),
    .rd_n(rdn[0]), .address(adr[0]), .dout(dout[0]), .busy(bsy[0]));

  opl2_host_writer #(.STROBE_LEN(SL1), .ADDR_WAIT(AW1), .DATA_WAIT(DW1),
                     .CNT_WIDTH(16), .SKIP_REDUNDANT_ADDR(SK1), .REG_FILE_DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_reg(creg[1]), .cmd_data(cdat[1]), .cs_n(csn[1]), .wr_n(wrn[1]),
    .rd_n(rdn[1]), .address(adr[1]), .dout(dout[1]), .busy(bsy[1]));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: a command is a fixed timeline of positions; outputs are a function of position.
  bit         mbusy [2], mfull [2], lval [2], hadr [2], acc [2];
  int         mpos [2], mlen [2], moff [2], acc_cyc [2];
  logic [7:0] mreg [2], mdat [2], lreg [2], hdout [2];

  int viol = 0, nstrb = 0;
  logic prev1 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, wanted event", name);
  endtask

  function automatic logic [10:0] exp_out(input int i, input int p);
    int q;
    logic a, s;
    logic [7:0] d;
    if (mfull[i] && p < moff[i]) begin
      a = 1'b0; d = mreg[i]; q = p;
    end else begin
      a = 1'b1; d = mdat[i]; q = p - moff[i];
    end
    s = (q >= 1) && (q <= SL[i]);
    return {~s, ~s, a, d};
  endfunction

  initial begin
    logic [10:0] ev;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          mbusy[i] = 0; hadr[i] = 0; hdout[i] = 8'h00; lval[i] = 0; lreg[i] = 8'h00;
        end
      end else begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (!mbusy[i] && cv[i]) begin
            mfull[i]   = !(SK[i] != 0 && lval[i] && creg[i] == lreg[i]);
            mreg[i]    = creg[i];
            mdat[i]    = cdat[i];
            moff[i]    = mfull[i] ? 1 + SL[i] + AW[i] : 0;
            mlen[i]    = moff[i] + 1 + SL[i] + DW[i];
            mpos[i]    = 0;
            mbusy[i]   = 1;
            acc[i]     = 1;
            acc_cyc[i] = cyc;
          end else if (mbusy[i]) begin
            mpos[i]++;
            if (mpos[i] == mlen[i]) mbusy[i] = 0;
          end
          if (mbusy[i]) begin
            ev       = exp_out(i, mpos[i]);
            hadr[i]  = ev[8];
            hdout[i] = ev[7:0];
            if (mfull[i] && mpos[i] == SL[i]) begin
              lval[i] = 1; lreg[i] = mreg[i];
            end
          end
        end
      end
    end
  end

  initial begin
    logic [10:0] ev;
    logic [13:0] e, a;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          if (mbusy[i]) begin
            ev = exp_out(i, mpos[i]);
            e  = {ev[10:9], 1'b1, ev[8], ev[7:0], 1'b1, 1'b0};
          end else begin
            e  = {3'b111, hadr[i], hdout[i], 1'b0, !reset};
          end
          a = {csn[i], wrn[i], rdn[i], adr[i], dout[i], bsy[i], rdy[i]};
          check(i == 0 ? "cycle_dut0" : "cycle_dut1", 32'(a), 32'(e));
        end
        if (csn[1] == 1'b0 && prev1 == 1'b0) viol++;
        if (csn[1] == 1'b0 && prev1 == 1'b1) nstrb++;
        prev1 = csn[1];
      end
    end
  end

  task automatic wait_acc(input int i, output bit ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc[i]) begin
        ok = 1;
        break;
      end
    end
    acc[i] = 0;
    if (!ok) timeout("accept");
  endtask

  task automatic write0(input logic [7:0] r, input logic [7:0] d, input int exp_lat, input bit full);
    bit ok;
    int k, dpos;
    cv[0] = 1; creg[0] = r; cdat[0] = d;
    wait_acc(0, ok);
    cv[0] = 0;
    if (!ok) return;
    dpos = full ? 2 + SL0 + AW0 : 1;
    check("model_len", mlen[0], exp_lat);
    k = 0;
    while (!rdy[0] && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        cdat[0] = ~d; creg[0] = ~r;
      end
      if (full && k == 1) check("a_strobe", {adr[0], dout[0], csn[0], wrn[0]}, {1'b0, r, 2'b00});
      if (k == dpos) check("d_strobe", {adr[0], dout[0], csn[0], wrn[0]}, {1'b1, d, 2'b00});
    end
    check("latency", k, exp_lat);
  endtask

  initial begin
    bit ok;
    int prev, k;
    logic [7:0] sr [4];
    logic [7:0] sd [4];
    sr = '{8'h20, 8'hA0, 8'h20, 8'h20};
    sd = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 2; i++) begin
      cv[i] = 0; creg[i] = 8'h00; cdat[i] = 8'h00; acc[i] = 0;
    end
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    check("reset_state", {csn[0], wrn[0], rdn[0], adr[0], dout[0], bsy[0], rdy[0]}, 14'b111_0_00000000_0_0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    write0(8'h20, 8'h01, 34, 1'b1);
    write0(8'h20, 8'h55, 27, 1'b0);

    // Abort mid data strobe, then rewrite the same register.
    cv[0] = 1; creg[0] = 8'h30; cdat[0] = 8'h99;
    wait_acc(0, ok);
    cv[0] = 0;
    k = 0;
    while (!(mbusy[0] && mpos[0] == 2 + SL0 + AW0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("strobe_before_reset", {csn[0], adr[0]}, 2'b01);
    #2 reset = 1'b1;
    #1 check("reset_release", {csn[0], wrn[0], rdn[0], adr[0], dout[0], bsy[0], rdy[0]}, 14'b111_0_00000000_0_0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    write0(8'h30, 8'h5A, 34, 1'b1);

    // Continuous stream on the zero-wait, no-skip instance.
    cv[1] = 1; creg[1] = sr[0]; cdat[1] = sd[0];
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      wait_acc(1, ok);
      if (!ok) break;
      if (j == 0) check("dut1_len", mlen[1], 4);
      else check("stream_interval", acc_cyc[1] - prev, 5);
      prev = acc_cyc[1];
      if (j < 3) begin
        creg[1] = sr[j+1]; cdat[1] = sd[j+1];
      end else cv[1] = 0;
    end
    repeat (10) @(negedge clk);
    check("dut1_strobes", nstrb, 8);
    check("dut1_adjacent_low", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
